// File: rtl/wb_sram_responder_if.sv
// Wishbone classic slave bus bundle between the wrapper's wbs_* pins and the SRAM responder.
interface wb_sram_responder_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_sram_responder.sv
// Wishbone classic-cycle slave driving port 0 of the OpenRAM 32x256 macro,
// with acknowledged read/write counters for the logic analyzer.
module wb_sram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00,
    parameter int unsigned SRAM_AW   = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_sram_responder_if.slave wbs,
    output logic               sram_csb0_o,
    output logic               sram_web0_o,
    output logic [3:0]         sram_wmask0_o,
    output logic [SRAM_AW-1:0] sram_addr0_o,
    output logic [31:0]        sram_din0_o,
    input  logic [31:0]        sram_dout0_i,
    output logic [15:0]        rd_cnt_o,
    output logic [15:0]        wr_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RDWAIT,
        ACK
    } state_t;

    state_t state;
    state_t state_next;

    logic               hit;
    logic               we_q;
    logic               ack_q;
    logic               ack_next;
    logic [31:0]        rdata_q;
    logic               csb_q;
    logic               csb_next;
    logic               web_q;
    logic               web_next;
    logic [3:0]         wmask_q;
    logic [3:0]         wmask_next;
    logic [SRAM_AW-1:0] addr_q;
    logic [31:0]        din_q;
    logic               load;
    logic               capture;
    logic               count_rd;
    logic               count_wr;
    logic [15:0]        rd_count;
    logic [15:0]        wr_count;

    assign hit = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                 ((wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic also computes the values the registered SRAM controls
    // and ack take on entry to the next state, so every output is a flop.
    always_comb begin
        state_next = state;
        ack_next   = 1'b0;
        csb_next   = 1'b1;
        web_next   = 1'b1;
        wmask_next = 4'h0;
        load       = 1'b0;
        capture    = 1'b0;
        count_rd   = 1'b0;
        count_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_next = MEM;
                    load       = 1'b1;
                    csb_next   = 1'b0;
                    web_next   = ~wbs.wbs_we_i;
                    wmask_next = wbs.wbs_we_i ? wbs.wbs_sel_i : 4'h0;
                end
            end
            MEM: begin
                if (!wbs.wbs_cyc_i) begin
                    state_next = IDLE;
                end else if (we_q) begin
                    state_next = ACK;
                    ack_next   = 1'b1;
                end else begin
                    state_next = RDWAIT;
                end
            end
            RDWAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    state_next = IDLE;
                end else begin
                    state_next = ACK;
                    ack_next   = 1'b1;
                    capture    = 1'b1;
                end
            end
            ACK: begin
                state_next = IDLE;
                count_rd   = wbs.wbs_cyc_i & ~we_q;
                count_wr   = wbs.wbs_cyc_i & we_q;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q    <= 1'b0;
            rdata_q  <= 32'h0;
            csb_q    <= 1'b1;
            web_q    <= 1'b1;
            wmask_q  <= 4'h0;
            addr_q   <= '0;
            din_q    <= 32'h0;
            we_q     <= 1'b0;
            rd_count <= 16'h0;
            wr_count <= 16'h0;
        end else begin
            ack_q   <= ack_next;
            csb_q   <= csb_next;
            web_q   <= web_next;
            wmask_q <= wmask_next;
            if (load) begin
                addr_q <= wbs.wbs_adr_i[SRAM_AW+1:2];
                din_q  <= wbs.wbs_dat_i;
                we_q   <= wbs.wbs_we_i;
            end
            if (capture) begin
                rdata_q <= sram_dout0_i;
            end
            if (count_rd) begin
                rd_count <= rd_count + 16'd1;
            end
            if (count_wr) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = rdata_q;
    assign sram_csb0_o   = csb_q;
    assign sram_web0_o   = web_q;
    assign sram_wmask0_o = wmask_q;
    assign sram_addr0_o  = addr_q;
    assign sram_din0_o   = din_q;
    assign rd_cnt_o      = rd_count;
    assign wr_cnt_o      = wr_count;

endmodule
